// File: rtl/axi4_burst_mst.sv
// Single-outstanding AXI4 INCR burst initiator: one command in, one AW/W/B or AR/R burst out.
// Build option AXI4_MST_RLAST_CHK_EN: a misplaced slave RLAST turns the read response into SLVERR.
//
// state    | meaning
// IDLE     | ready for a command
// WR_ADDR  | AWVALID held until AWREADY
// WR_DATA  | streaming write beats from wr_* onto W
// WR_RESP  | waiting for the B response
// RD_ADDR  | ARVALID held until ARREADY
// RD_DATA  | streaming read beats from R onto rd_*
module axi4_burst_mst #(
  parameter int DATA_W           = 256,
  parameter int ADDR_W           = 32,
  parameter int MST_ID_W         = 5,
  parameter int MST_ID           = 0,
  parameter int TRANS_DATA_LEN_W = 8,
  parameter int TRANS_RESP_W     = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cmd_wr_i,
  input  logic [ADDR_W-1:0]           cmd_addr_i,
  input  logic [TRANS_DATA_LEN_W-1:0] cmd_len_i,
  input  logic                        cmd_vld_i,
  output logic                        cmd_rdy_o,
  input  logic [DATA_W-1:0]           wr_data_i,
  input  logic                        wr_vld_i,
  output logic                        wr_rdy_o,
  output logic [DATA_W-1:0]           rd_data_o,
  output logic                        rd_last_o,
  output logic                        rd_vld_o,
  input  logic                        rd_rdy_i,
  output logic                        done_o,
  output logic [TRANS_RESP_W-1:0]     resp_o,
  output logic [MST_ID_W-1:0]         m_awid_o,
  output logic [ADDR_W-1:0]           m_awaddr_o,
  output logic [1:0]                  m_awburst_o,
  output logic [TRANS_DATA_LEN_W-1:0] m_awlen_o,
  output logic                        m_awvalid_o,
  input  logic                        m_awready_i,
  output logic [DATA_W-1:0]           m_wdata_o,
  output logic                        m_wlast_o,
  output logic                        m_wvalid_o,
  input  logic                        m_wready_i,
  input  logic [MST_ID_W-1:0]         m_bid_i,
  input  logic [TRANS_RESP_W-1:0]     m_bresp_i,
  input  logic                        m_bvalid_i,
  output logic                        m_bready_o,
  output logic [MST_ID_W-1:0]         m_arid_o,
  output logic [ADDR_W-1:0]           m_araddr_o,
  output logic [1:0]                  m_arburst_o,
  output logic [TRANS_DATA_LEN_W-1:0] m_arlen_o,
  output logic                        m_arvalid_o,
  input  logic                        m_arready_i,
  input  logic [MST_ID_W-1:0]         m_rid_i,
  input  logic [DATA_W-1:0]           m_rdata_i,
  input  logic [TRANS_RESP_W-1:0]     m_rresp_i,
  input  logic                        m_rlast_i,
  input  logic                        m_rvalid_i,
  output logic                        m_rready_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_ADDR, S_WR_DATA, S_WR_RESP, S_RD_ADDR, S_RD_DATA
  } state_t;

  localparam logic [TRANS_RESP_W-1:0]   RESP_SLVERR = TRANS_RESP_W'(2);
  localparam logic [TRANS_DATA_LEN_W:0] CNT_ONE     = (TRANS_DATA_LEN_W+1)'(1);

  state_t                        state_q, state_d;
  logic [ADDR_W-1:0]             addr_q;
  logic [TRANS_DATA_LEN_W-1:0]   len_q;
  logic [TRANS_DATA_LEN_W:0]     cnt_q;
  logic [TRANS_RESP_W-1:0]       resp_q;
  logic                          done_q;
  logic                          err_q;
  logic                          beat_last;
  logic                          w_hs;
  logic                          r_hs;
  logic                          rlast_bad;
  logic [TRANS_RESP_W-1:0]       rresp_max;
  logic                          unused_ok;

  // IDs are not checked: only one burst is ever in flight.
  assign unused_ok = ^{m_bid_i, m_rid_i, m_rlast_i};

  assign beat_last = (cnt_q == {1'b0, len_q});
  assign w_hs      = (state_q == S_WR_DATA) && wr_vld_i && m_wready_i;
  assign r_hs      = (state_q == S_RD_DATA) && m_rvalid_i && rd_rdy_i;
  assign rresp_max = (m_rresp_i > resp_q) ? m_rresp_i : resp_q;

`ifdef AXI4_MST_RLAST_CHK_EN
  assign rlast_bad = (m_rlast_i != beat_last);
`else
  assign rlast_bad = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      resp_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cmd_vld_i) begin
            addr_q <= cmd_addr_i;
            len_q  <= cmd_len_i;
            cnt_q  <= '0;
            resp_q <= '0;
            err_q  <= 1'b0;
          end
        end
        S_WR_DATA: begin
          if (w_hs) cnt_q <= cnt_q + CNT_ONE;
        end
        S_WR_RESP: begin
          if (m_bvalid_i) begin
            resp_q <= m_bresp_i;
            done_q <= 1'b1;
          end
        end
        S_RD_DATA: begin
          if (r_hs) begin
            cnt_q  <= cnt_q + CNT_ONE;
            resp_q <= rresp_max;
            if (rlast_bad) err_q <= 1'b1;
            // An RLAST error anywhere in the burst overrides the accumulated RRESP.
            if (beat_last) begin
              done_q <= 1'b1;
              if (err_q || rlast_bad) resp_q <= RESP_SLVERR;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d     = state_q;
    cmd_rdy_o   = 1'b0;
    m_awvalid_o = 1'b0;
    m_wvalid_o  = 1'b0;
    m_wlast_o   = 1'b0;
    wr_rdy_o    = 1'b0;
    m_bready_o  = 1'b0;
    m_arvalid_o = 1'b0;
    m_rready_o  = 1'b0;
    rd_vld_o    = 1'b0;
    rd_last_o   = 1'b0;
    case (state_q)
      S_IDLE: begin
        cmd_rdy_o = 1'b1;
        if (cmd_vld_i) state_d = cmd_wr_i ? S_WR_ADDR : S_RD_ADDR;
      end
      S_WR_ADDR: begin
        m_awvalid_o = 1'b1;
        if (m_awready_i) state_d = S_WR_DATA;
      end
      S_WR_DATA: begin
        m_wvalid_o = wr_vld_i;
        wr_rdy_o   = m_wready_i;
        m_wlast_o  = beat_last;
        if (w_hs && beat_last) state_d = S_WR_RESP;
      end
      S_WR_RESP: begin
        m_bready_o = 1'b1;
        if (m_bvalid_i) state_d = S_IDLE;
      end
      S_RD_ADDR: begin
        m_arvalid_o = 1'b1;
        if (m_arready_i) state_d = S_RD_DATA;
      end
      S_RD_DATA: begin
        rd_vld_o   = m_rvalid_i;
        m_rready_o = rd_rdy_i;
        rd_last_o  = beat_last;
        if (r_hs && beat_last) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign m_awid_o    = MST_ID_W'(MST_ID);
  assign m_awaddr_o  = addr_q;
  assign m_awburst_o = 2'b01;
  assign m_awlen_o   = len_q;
  assign m_arid_o    = MST_ID_W'(MST_ID);
  assign m_araddr_o  = addr_q;
  assign m_arburst_o = 2'b01;
  assign m_arlen_o   = len_q;
  assign m_wdata_o   = wr_data_i;
  assign rd_data_o   = m_rdata_i;
  assign done_o      = done_q;
  assign resp_o      = resp_q;

endmodule

// File: tb/tb_axi4_burst_mst.sv
// Scoreboard bench for axi4_burst_mst: directed bursts against a small behavioural AXI slave.
// Expected RLAST-error response depends on AXI4_MST_RLAST_CHK_EN.
module tb_axi4_burst_mst;

  logic         clk = 1'b0;
  logic         rst;
  logic         cmd_wr_i, cmd_vld_i, cmd_rdy_o;
  logic [31:0]  cmd_addr_i;
  logic [7:0]   cmd_len_i;
  logic [255:0] wr_data_i, rd_data_o, m_wdata_o, m_rdata_i;
  logic         wr_vld_i, wr_rdy_o, rd_last_o, rd_vld_o, rd_rdy_i, done_o;
  logic [1:0]   resp_o, m_awburst_o, m_arburst_o, m_bresp_i, m_rresp_i;
  logic [4:0]   m_awid_o, m_arid_o, m_bid_i, m_rid_i;
  logic [31:0]  m_awaddr_o, m_araddr_o;
  logic [7:0]   m_awlen_o, m_arlen_o;
  logic         m_awvalid_o, m_awready_i, m_wlast_o, m_wvalid_o, m_wready_i;
  logic         m_bvalid_i, m_bready_o, m_arvalid_o, m_arready_i;
  logic         m_rlast_i, m_rvalid_i, m_rready_o;

  axi4_burst_mst dut (
    .clk(clk), .rst(rst),
    .cmd_wr_i(cmd_wr_i), .cmd_addr_i(cmd_addr_i), .cmd_len_i(cmd_len_i),
    .cmd_vld_i(cmd_vld_i), .cmd_rdy_o(cmd_rdy_o),
    .wr_data_i(wr_data_i), .wr_vld_i(wr_vld_i), .wr_rdy_o(wr_rdy_o),
    .rd_data_o(rd_data_o), .rd_last_o(rd_last_o), .rd_vld_o(rd_vld_o), .rd_rdy_i(rd_rdy_i),
    .done_o(done_o), .resp_o(resp_o),
    .m_awid_o(m_awid_o), .m_awaddr_o(m_awaddr_o), .m_awburst_o(m_awburst_o),
    .m_awlen_o(m_awlen_o), .m_awvalid_o(m_awvalid_o), .m_awready_i(m_awready_i),
    .m_wdata_o(m_wdata_o), .m_wlast_o(m_wlast_o), .m_wvalid_o(m_wvalid_o), .m_wready_i(m_wready_i),
    .m_bid_i(m_bid_i), .m_bresp_i(m_bresp_i), .m_bvalid_i(m_bvalid_i), .m_bready_o(m_bready_o),
    .m_arid_o(m_arid_o), .m_araddr_o(m_araddr_o), .m_arburst_o(m_arburst_o),
    .m_arlen_o(m_arlen_o), .m_arvalid_o(m_arvalid_o), .m_arready_i(m_arready_i),
    .m_rid_i(m_rid_i), .m_rdata_i(m_rdata_i), .m_rresp_i(m_rresp_i), .m_rlast_i(m_rlast_i),
    .m_rvalid_i(m_rvalid_i), .m_rready_o(m_rready_o)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [31:0] addr; logic [7:0] len; } ax_t;
  typedef struct packed { logic [255:0] data; logic last; } beat_t;

  ax_t        exp_aw[$], exp_ar[$];
  beat_t      exp_w[$], exp_rd[$];
  logic [1:0] exp_done[$];
  int         passed = 0, total = 0;

  // slave / source behaviour knobs
  int         aw_delay = 0, rresp_err_beat = -1, bad_rlast_beat = -1, r_base = 0;
  bit         wr_rand = 0, rd_tog = 0;
  logic [1:0] b_resp = 2'b00, rresp_base = 2'b00, rresp_err_val = 2'b00;

  // handshakes seen just before the most recent rising edge
  logic       hs_cmd, hs_aw, hs_w, hs_wlast, hs_b, hs_ar, hs_r;
  logic [7:0] hs_arlen;
  logic       axv_due = 0, aw_hs_prev = 0, ar_hs_prev = 0, done_due = 0;
  int         wbeat = 0, aw_cnt = 0, ridx = 0, r_n = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic chkd(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic fail_bound(input string name);
    total++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  function automatic logic [255:0] wpat(input int i);
    logic [31:0] w;
    w = 32'hC0DE_0000 + i;
    return {8{w}};
  endfunction

  function automatic logic [255:0] rpat(input int base, input int i);
    logic [31:0] w;
    w = 32'hA5A5_0000 + base + i;
    return {8{w}};
  endfunction

  // behavioural AXI slave and write-data source
  initial begin
    m_awready_i = 1'b0; m_wready_i = 1'b0; m_bvalid_i = 1'b0; m_bresp_i = 2'b00;
    m_bid_i = '0; m_rid_i = '0; m_arready_i = 1'b1; m_rvalid_i = 1'b0;
    m_rdata_i = '0; m_rresp_i = 2'b00; m_rlast_i = 1'b0; rd_rdy_i = 1'b1;
    wr_data_i = wpat(0);
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        aw_cnt = 0; m_awready_i = 1'b0; m_bvalid_i = 1'b0;
        r_n = 0; ridx = 0; m_rvalid_i = 1'b0; wbeat = 0;
      end else begin
        if (m_awvalid_o) aw_cnt++;
        else aw_cnt = 0;
        m_awready_i = m_awvalid_o && (aw_cnt > aw_delay);
        m_wready_i  = wr_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        if (hs_wlast) wbeat = 0;
        else if (hs_w) wbeat++;
        wr_data_i = wpat(wbeat);
        if (hs_b) m_bvalid_i = 1'b0;
        if (hs_wlast) begin
          m_bvalid_i = 1'b1;
          m_bresp_i  = b_resp;
        end
        if (hs_ar) begin
          r_n  = int'(hs_arlen) + 1;
          ridx = 0;
        end else if (hs_r) ridx++;
        m_rvalid_i = (ridx < r_n);
        m_rdata_i  = rpat(r_base, ridx);
        m_rresp_i  = (ridx == rresp_err_beat) ? rresp_err_val : rresp_base;
        m_rlast_i  = (bad_rlast_beat >= 0) ? (ridx == bad_rlast_beat) : (ridx == r_n - 1);
      end
      rd_rdy_i = rd_tog ? ~rd_rdy_i : 1'b1;
    end
  end

  // monitor / scoreboard
  always @(negedge clk) begin : mon
    ax_t   a;
    beat_t b;
    logic  fin;
    hs_cmd   = cmd_vld_i & cmd_rdy_o;
    hs_aw    = m_awvalid_o & m_awready_i;
    hs_w     = m_wvalid_o & m_wready_i;
    hs_wlast = hs_w & m_wlast_o;
    hs_b     = m_bvalid_i & m_bready_o;
    hs_ar    = m_arvalid_o & m_arready_i;
    hs_arlen = m_arlen_o;
    hs_r     = m_rvalid_i & m_rready_o;
    fin      = hs_b;
    if (!rst) begin
      if (axv_due) chk1("axvalid_after_cmd", m_awvalid_o | m_arvalid_o, 1'b1);
      if (hs_cmd) chk1("axvalid_not_early", m_awvalid_o | m_arvalid_o, 1'b0);
      if (aw_hs_prev) chk1("w_first_beat", m_wvalid_o, wr_vld_i);
      if (ar_hs_prev && m_rvalid_i) chk1("r_first_beat", rd_vld_o, 1'b1);
      if (m_awvalid_o) begin
        if (exp_aw.size() == 0) chk1("aw_unexpected", m_awvalid_o, 1'b0);
        else begin
          a = exp_aw[0];
          chk32("awaddr", m_awaddr_o, a.addr);
          chk32("awlen", 32'(m_awlen_o), 32'(a.len));
          chk32("awburst", 32'(m_awburst_o), 32'd1);
          chk32("awid", 32'(m_awid_o), 32'd0);
          if (hs_aw) void'(exp_aw.pop_front());
        end
      end
      if (hs_w) begin
        chk1("wr_rdy", wr_rdy_o, m_wready_i);
        if (exp_w.size() == 0) chk1("w_unexpected", m_wvalid_o, 1'b0);
        else begin
          b = exp_w.pop_front();
          chkd("wdata", m_wdata_o, b.data);
          chk1("wlast", m_wlast_o, b.last);
        end
      end
      if (m_arvalid_o) begin
        if (exp_ar.size() == 0) chk1("ar_unexpected", m_arvalid_o, 1'b0);
        else begin
          a = exp_ar[0];
          chk32("araddr", m_araddr_o, a.addr);
          chk32("arlen", 32'(m_arlen_o), 32'(a.len));
          chk32("arburst", 32'(m_arburst_o), 32'd1);
          chk32("arid", 32'(m_arid_o), 32'd0);
          if (hs_ar) void'(exp_ar.pop_front());
        end
      end
      if (rd_vld_o) begin
        chk1("rready_mirror", m_rready_o, rd_rdy_i);
        if (rd_rdy_i) begin
          if (exp_rd.size() == 0) chk1("rd_unexpected", rd_vld_o, 1'b0);
          else begin
            b = exp_rd.pop_front();
            chkd("rd_data", rd_data_o, b.data);
            chk1("rd_last", rd_last_o, b.last);
            if (b.last) fin = 1'b1;
          end
        end
      end
      if (done_due || done_o) begin
        chk1("done_timing", done_o, done_due);
        if (done_due) chk1("cmd_rdy_after_done", cmd_rdy_o, 1'b1);
        if (done_o) begin
          if (exp_done.size() == 0) chk1("done_unexpected", done_o, 1'b0);
          else chk32("resp", 32'(resp_o), 32'(exp_done.pop_front()));
        end
      end
    end
    axv_due    = hs_cmd & ~rst;
    aw_hs_prev = hs_aw & ~rst;
    ar_hs_prev = hs_ar & ~rst;
    done_due   = fin & ~rst;
  end

  task automatic issue(input logic wr, input logic [31:0] addr, input logic [7:0] len,
                       input logic [1:0] resp, input bit want_done);
    ax_t   a;
    beat_t b;
    bit    ok;
    a.addr = addr;
    a.len  = len;
    if (wr) exp_aw.push_back(a);
    else exp_ar.push_back(a);
    for (int i = 0; i <= int'(len); i++) begin
      b.last = (i == int'(len));
      b.data = wr ? wpat(i) : rpat(r_base, i);
      if (wr) exp_w.push_back(b);
      else exp_rd.push_back(b);
    end
    if (want_done) exp_done.push_back(resp);
    cmd_wr_i = wr; cmd_addr_i = addr; cmd_len_i = len; cmd_vld_i = 1'b1;
    ok = 0;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(posedge clk);
      #2;
      ok = hs_cmd;
    end
    cmd_vld_i = 1'b0;
    if (!ok) fail_bound("cmd_accept");
  endtask

  task automatic wait_done(input string name);
    for (int n = 0; n < 3000 && exp_done.size() != 0; n++) begin
      @(posedge clk);
      #2;
    end
    if (exp_done.size() != 0) begin
      fail_bound(name);
      exp_done.delete();
    end
    repeat (2) @(posedge clk);
    #2;
    chk32({name, "_beats_left"}, 32'(exp_w.size() + exp_rd.size() + exp_aw.size() + exp_ar.size()), 32'd0);
    exp_w.delete(); exp_rd.delete(); exp_aw.delete(); exp_ar.delete();
  endtask

  initial begin
    rst = 1'b1; cmd_vld_i = 1'b0; cmd_wr_i = 1'b0; cmd_addr_i = '0; cmd_len_i = '0;
    wr_vld_i = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk1("rst_cmd_rdy", cmd_rdy_o, 1'b1);
    chk1("rst_awvalid", m_awvalid_o, 1'b0);
    chk1("rst_wvalid", m_wvalid_o, 1'b0);
    chk1("rst_arvalid", m_arvalid_o, 1'b0);
    chk1("rst_bready", m_bready_o, 1'b0);
    chk1("rst_rready", m_rready_o, 1'b0);
    chk1("rst_wr_rdy", wr_rdy_o, 1'b0);
    chk1("rst_rd_vld", rd_vld_o, 1'b0);
    chk1("rst_rd_last", rd_last_o, 1'b0);
    chk1("rst_done", done_o, 1'b0);
    chk32("rst_resp", 32'(resp_o), 32'd0);
    chk32("rst_awaddr", m_awaddr_o, 32'd0);
    chk32("rst_araddr", m_araddr_o, 32'd0);
    chk32("rst_awlen", 32'(m_awlen_o), 32'd0);
    chk32("rst_awid", 32'(m_awid_o), 32'd0);
    @(posedge clk);
    #2;
    rst = 1'b0;

    // write len 3, everything ready
    issue(1'b1, 32'h0000_0040, 8'd3, 2'b00, 1'b1);
    wait_done("wr_len3");

    // single-beat read
    r_base = 16;
    issue(1'b0, 32'h0000_0000, 8'd0, 2'b00, 1'b1);
    wait_done("rd_len0");

    // read len 7, rd_rdy toggling, SLVERR on beat 5
    r_base = 32; rd_tog = 1; rresp_err_beat = 4; rresp_err_val = 2'b10;
    issue(1'b0, 32'h0000_0100, 8'd7, 2'b10, 1'b1);
    wait_done("rd_len7");
    rd_tog = 0; rresp_err_beat = -1;

    // 256-beat write, AW stalled 5 cycles, random WREADY, EXOKAY response
    aw_delay = 5; wr_rand = 1; b_resp = 2'b01;
    issue(1'b1, 32'h0000_1000, 8'd255, 2'b01, 1'b1);
    wait_done("wr_len255");
    aw_delay = 0; wr_rand = 0; b_resp = 2'b00;

    // early RLAST on beat 2
    r_base = 64; bad_rlast_beat = 1;
`ifdef AXI4_MST_RLAST_CHK_EN
    issue(1'b0, 32'h0000_0200, 8'd3, 2'b10, 1'b1);
`else
    issue(1'b0, 32'h0000_0200, 8'd3, 2'b00, 1'b1);
`endif
    wait_done("rd_bad_rlast");
    bad_rlast_beat = -1;

    // response is the maximum, not an OR: 01 then 10 -> 10
    r_base = 96; rresp_base = 2'b01; rresp_err_beat = 1; rresp_err_val = 2'b10;
    issue(1'b0, 32'h0000_0400, 8'd2, 2'b10, 1'b1);
    wait_done("rd_resp_max");
    rresp_base = 2'b00; rresp_err_beat = -1;

    // reset during the second write beat
    issue(1'b1, 32'h0000_0300, 8'd3, 2'b00, 1'b0);
    for (int n = 0; n < 100 && wbeat != 1; n++) begin
      @(posedge clk);
      #2;
    end
    if (wbeat != 1) fail_bound("rst_beat_wait");
    rst = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
    exp_w.delete(); exp_aw.delete();
    @(negedge clk);
    chk1("mid_rst_cmd_rdy", cmd_rdy_o, 1'b1);
    chk1("mid_rst_awvalid", m_awvalid_o, 1'b0);
    chk1("mid_rst_wvalid", m_wvalid_o, 1'b0);
    chk1("mid_rst_arvalid", m_arvalid_o, 1'b0);
    chk1("mid_rst_bready", m_bready_o, 1'b0);
    chk1("mid_rst_done", done_o, 1'b0);
    repeat (6) @(posedge clk);
    #2;

    // recovery after reset
    r_base = 128;
    issue(1'b0, 32'h0000_0080, 8'd1, 2'b00, 1'b1);
    wait_done("rd_after_rst");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
